// File: rtl/motor_throttle_sequencer.sv
// Rate-limited throttle level sequencer with brake override and motor gating.
// Optional command-loss watchdog and FAULT state enabled by THROTTLE_WATCHDOG_EN.
module motor_throttle_sequencer #(
    parameter int RAMP_DIV      = 5000,
    parameter int STEP          = 4,
    parameter int MAX_LEVEL     = 4095,
    parameter int TIMEOUT_TICKS = 25000000
) (
    input  logic        pwm_clock_i,
    input  logic        n_reset_i,
    input  logic        enable_i,
    input  logic        brake_i,
    input  logic [11:0] target_i,
    input  logic        target_valid_i,
    input  logic        fault_clear_i,
    output logic [11:0] level_o,
    output logic        motor_on_o,
    output logic        at_target_o,
    output logic        fault_o,
    output logic [2:0]  state_o
);
    // state | meaning
    // IDLE  | level 0, motor off, waiting for enable with nonzero target
    // RAMP  | stepping level toward latched target once per tick
    // HOLD  | level equals latched target
    // STOP  | enable dropped, stepping level toward 0
    // FAULT | command loss, motor off until cleared with enable low

    localparam int                TICK_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_DIV - 1);
    localparam logic [11:0]       MAX_LVL   = 12'(MAX_LEVEL);
    localparam logic [12:0]       STEP_13   = 13'(STEP);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RAMP  = 3'd1,
        S_HOLD  = 3'd2,
        S_STOP  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [11:0]       level_q, level_d;
    logic [11:0]       tgt_q, tgt_d;
    logic              motor_on_q, motor_on_d;
    logic              at_target_q, at_target_d;
    logic              fault_q, fault_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic              wdog_trip;
    logic [11:0]       tgt_in;
    logic [11:0]       stepped;

    // Signed 13-bit difference keeps the step from overshooting or wrapping.
    function automatic logic [11:0] step_toward(input logic [11:0] cur, input logic [11:0] goal);
        logic signed [12:0] diff;
        logic [12:0]        mag;
        logic [12:0]        amt;
        diff = $signed({1'b0, goal}) - $signed({1'b0, cur});
        mag  = diff[12] ? $unsigned(-diff) : $unsigned(diff);
        amt  = (mag < STEP_13) ? mag : STEP_13;
        step_toward = diff[12] ? (cur - amt[11:0]) : (cur + amt[11:0]);
    endfunction

    assign tgt_in  = (target_i > MAX_LVL) ? MAX_LVL : target_i;
    assign tick    = (tick_cnt_q == TICK_LAST);
    assign stepped = step_toward(level_q, (state_q == S_STOP) ? 12'd0 : tgt_q);

`ifdef THROTTLE_WATCHDOG_EN
    localparam int              WD_W    = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_TICKS - 1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            active;

    assign active = (state_q == S_RAMP) || (state_q == S_HOLD) || (state_q == S_STOP);

    always_comb begin
        wdog_d    = '0;
        wdog_trip = 1'b0;
        if (active && !target_valid_i) begin
            wdog_d    = wdog_q + 1'b1;
            wdog_trip = (wdog_q >= WD_LAST);
        end
    end

    always_ff @(posedge pwm_clock_i) begin
        if (!n_reset_i) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_trip = 1'b0;
`endif

    always_comb begin
        tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
        tgt_d       = tgt_q;
        state_d     = state_q;
        level_d     = level_q;
        motor_on_d  = motor_on_q;
        at_target_d = at_target_q;
        fault_d     = fault_q;

        if (target_valid_i && (state_q != S_FAULT)) begin
            tgt_d = tgt_in;
        end

        if (state_q == S_FAULT) begin
            if (fault_clear_i && !enable_i) begin
                state_d = S_IDLE;
                fault_d = 1'b0;
            end
        end else if (brake_i) begin
            state_d     = S_IDLE;
            level_d     = 12'd0;
            motor_on_d  = 1'b0;
            at_target_d = 1'b0;
        end else if (wdog_trip) begin
            state_d     = S_FAULT;
            level_d     = 12'd0;
            motor_on_d  = 1'b0;
            at_target_d = 1'b0;
            fault_d     = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    level_d    = 12'd0;
                    motor_on_d = 1'b0;
                    if (enable_i && (tgt_q != 12'd0)) begin
                        state_d    = S_RAMP;
                        motor_on_d = 1'b1;
                    end
                end
                S_RAMP: begin
                    if (!enable_i) begin
                        state_d = S_STOP;
                    end else if (tick) begin
                        level_d = stepped;
                        if (stepped == tgt_q) begin
                            if (tgt_q != 12'd0) begin
                                state_d     = S_HOLD;
                                at_target_d = 1'b1;
                            end else begin
                                state_d    = S_IDLE;
                                motor_on_d = 1'b0;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (!enable_i) begin
                        state_d     = S_STOP;
                        at_target_d = 1'b0;
                    end else if (tgt_q != level_q) begin
                        state_d     = S_RAMP;
                        at_target_d = 1'b0;
                    end
                end
                S_STOP: begin
                    if (enable_i) begin
                        state_d = S_RAMP;
                    end else if (tick) begin
                        level_d = stepped;
                        if (stepped == 12'd0) begin
                            state_d    = S_IDLE;
                            motor_on_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    level_d     = 12'd0;
                    motor_on_d  = 1'b0;
                    at_target_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge pwm_clock_i) begin
        if (!n_reset_i) begin
            state_q     <= S_IDLE;
            level_q     <= 12'd0;
            tgt_q       <= 12'd0;
            motor_on_q  <= 1'b0;
            at_target_q <= 1'b0;
            fault_q     <= 1'b0;
            tick_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            tgt_q       <= tgt_d;
            motor_on_q  <= motor_on_d;
            at_target_q <= at_target_d;
            fault_q     <= fault_d;
            tick_cnt_q  <= tick_cnt_d;
        end
    end

    assign level_o     = level_q;
    assign motor_on_o  = motor_on_q;
    assign at_target_o = at_target_q;
    assign fault_o     = fault_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_motor_throttle_sequencer.sv
// Self-checking bench for motor_throttle_sequencer; follows THROTTLE_WATCHDOG_EN when defined.
module tb_motor_throttle_sequencer;
    localparam int RAMP_DIV      = 4;
    localparam int STEP          = 4;
    localparam int MAX_LEVEL     = 100;
    localparam int TIMEOUT_TICKS = 200;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        enable = 1'b0;
    logic        brake = 1'b0;
    logic [11:0] target = 12'd0;
    logic        tv = 1'b0;
    logic        fclr = 1'b0;
    logic [11:0] level_o;
    logic        motor_on_o, at_target_o, fault_o;
    logic [2:0]  state_o;
    logic [17:0] dut_vec;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: spec-level state number, level, latched target, tick phase, watchdog age.
    int m_state = 0, m_level = 0, m_tgt = 0, m_phase = 0, m_wd = 0;

    always #5 clk = ~clk;

    motor_throttle_sequencer #(
        .RAMP_DIV(RAMP_DIV), .STEP(STEP), .MAX_LEVEL(MAX_LEVEL), .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) dut (
        .pwm_clock_i(clk), .n_reset_i(n_reset), .enable_i(enable), .brake_i(brake),
        .target_i(target), .target_valid_i(tv), .fault_clear_i(fclr),
        .level_o(level_o), .motor_on_o(motor_on_o), .at_target_o(at_target_o),
        .fault_o(fault_o), .state_o(state_o)
    );

    assign dut_vec = {level_o, motor_on_o, at_target_o, fault_o, state_o};

    function automatic int move_toward(int cur, int goal);
        if (goal > cur) return cur + ((goal - cur < STEP) ? goal - cur : STEP);
        return cur - ((cur - goal < STEP) ? cur - goal : STEP);
    endfunction

    function automatic logic [17:0] model_vec();
        logic mot, at, flt;
        mot = (m_state >= 1 && m_state <= 3);
        at  = (m_state == 2);
        flt = (m_state == 4);
        return {12'(m_level), mot, at, flt, 3'(m_state)};
    endfunction

    task automatic model_step();
        int ns, nl, nt;
        bit tk, active, trip;
        if (!n_reset) begin
            m_state = 0; m_level = 0; m_tgt = 0; m_phase = 0; m_wd = 0;
            return;
        end
        tk     = (m_phase == RAMP_DIV - 1);
        active = (m_state >= 1 && m_state <= 3);
        ns = m_state; nl = m_level; nt = m_tgt;
        if (tv && m_state != 4) nt = (int'(target) > MAX_LEVEL) ? MAX_LEVEL : int'(target);
`ifdef THROTTLE_WATCHDOG_EN
        trip = active && !tv && (m_wd + 1 >= TIMEOUT_TICKS);
`else
        trip = 1'b0;
`endif
        if (m_state == 4) begin
            if (fclr && !enable) ns = 0;
        end else if (brake) begin
            ns = 0; nl = 0;
        end else if (trip) begin
            ns = 4; nl = 0;
        end else begin
            case (m_state)
                0: if (enable && m_tgt > 0) ns = 1;
                1: if (!enable) ns = 3;
                   else if (tk) begin
                       nl = move_toward(m_level, m_tgt);
                       if (nl == m_tgt) ns = (m_tgt > 0) ? 2 : 0;
                   end
                2: if (!enable) ns = 3;
                   else if (m_tgt != m_level) ns = 1;
                3: if (enable) ns = 1;
                   else if (tk) begin
                       nl = move_toward(m_level, 0);
                       if (nl == 0) ns = 0;
                   end
                default: ;
            endcase
        end
        m_wd    = (active && !tv) ? m_wd + 1 : 0;
        m_phase = (m_phase + 1) % RAMP_DIV;
        m_state = ns; m_level = nl; m_tgt = nt;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_reset = 1'b0; enable = 1'b0; brake = 1'b0; tv = 1'b0; fclr = 1'b0; target = 12'd0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            vectors++;
            if (dut_vec !== 18'h0) begin
                miscompares++;
                $display("FAIL reset: got %h expected %h", dut_vec, 18'h0);
            end
        end
        n_reset = 1'b1;
    endtask

    task automatic test_ramp_up();
        int seen[$];
        int last = 0;
        bit done = 0;
        enable = 1'b1; tv = 1'b1; target = 12'd10;
        cycle();
        tv = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            cycle();
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL ramp_up cycle %0d: got %h expected %h", i, dut_vec, model_vec());
            end
            if (int'(level_o) != last) begin seen.push_back(int'(level_o)); last = int'(level_o); end
            if (state_o == 3'd2) done = 1;
        end
        vectors++;
        if (!done) begin miscompares++; $display("FAIL ramp_up_timeout: state %0d expected 2", state_o); end
        vectors++;
        if (seen.size() != 3 || seen[0] != 4 || seen[1] != 8 || seen[2] != 10) begin
            miscompares++;
            $display("FAIL ramp_up_steps: got %0d steps ending at %0d, expected 4,8,10", seen.size(), last);
        end
        vectors++;
        if (at_target_o !== 1'b1 || motor_on_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ramp_up_hold: at_target %b motor %b expected 1 1", at_target_o, motor_on_o);
        end
    endtask

    task automatic test_brake();
        bit done = 0;
        brake = 1'b1; tv = 1'b1; target = 12'd50;
        cycle();
        brake = 1'b0; tv = 1'b0;
        vectors++;
        if (dut_vec !== 18'h0) begin
            miscompares++;
            $display("FAIL brake_stop: got %h expected %h", dut_vec, 18'h0);
        end
        cycle();
        vectors++;
        if (state_o !== 3'd1 || motor_on_o !== 1'b1) begin
            miscompares++;
            $display("FAIL brake_release: state %0d motor %b expected 1 1", state_o, motor_on_o);
        end
        for (int i = 0; i < 100 && !done; i++) begin
            cycle();
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL brake_ramp cycle %0d: got %h expected %h", i, dut_vec, model_vec());
            end
            if (state_o == 3'd2) done = 1;
        end
        vectors++;
        if (level_o !== 12'd50 || !done) begin
            miscompares++;
            $display("FAIL brake_final: level %0d state %0d expected 50 2", level_o, state_o);
        end
    endtask

    task automatic test_stop();
        int seen[$];
        int last;
        bit done = 0;
        tv = 1'b1; target = 12'd10;
        cycle();
        tv = 1'b0;
        for (int i = 0; i < 80 && !(state_o == 3'd2 && level_o == 12'd10); i++) cycle();
        vectors++;
        if (state_o !== 3'd2 || level_o !== 12'd10) begin
            miscompares++;
            $display("FAIL stop_setup: state %0d level %0d expected 2 10", state_o, level_o);
        end
        last = int'(level_o);
        enable = 1'b0;
        cycle();
        vectors++;
        if (state_o !== 3'd3) begin
            miscompares++;
            $display("FAIL stop_enter: state %0d expected 3", state_o);
        end
        for (int i = 0; i < 30 && !done; i++) begin
            cycle();
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL stop_ramp cycle %0d: got %h expected %h", i, dut_vec, model_vec());
            end
            if (int'(level_o) != last) begin seen.push_back(int'(level_o)); last = int'(level_o); end
            if (state_o == 3'd0) done = 1;
        end
        vectors++;
        if (!done || motor_on_o !== 1'b0 || seen.size() != 3 || seen[0] != 6 || seen[1] != 2 || seen[2] != 0) begin
            miscompares++;
            $display("FAIL stop_steps: %0d steps ending %0d state %0d motor %b, expected 6,2,0 state 0 motor 0",
                     seen.size(), last, state_o, motor_on_o);
        end
    endtask

    task automatic test_clamp();
        int peak = 0;
        bit done = 0;
        enable = 1'b1; tv = 1'b1; target = 12'd3000 + 12'd2000;
        cycle();
        tv = 1'b0;
        for (int i = 0; i < 150 && !done; i++) begin
            cycle();
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL clamp cycle %0d: got %h expected %h", i, dut_vec, model_vec());
            end
            if (int'(level_o) > peak) peak = int'(level_o);
            if (state_o == 3'd2) done = 1;
        end
        vectors++;
        if (!done || level_o !== 12'd100 || peak > MAX_LEVEL) begin
            miscompares++;
            $display("FAIL clamp_final: level %0d peak %0d state %0d expected 100 100 2", level_o, peak, state_o);
        end
    endtask

    task automatic test_watchdog();
        bit hit = 0;
        bit fault_seen = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            cycle();
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL watchdog cycle %0d: got %h expected %h", i, dut_vec, model_vec());
            end
            if (fault_o === 1'b1) fault_seen = 1;
            if (state_o == 3'd4) hit = 1;
        end
`ifdef THROTTLE_WATCHDOG_EN
        vectors++;
        if (!hit || fault_o !== 1'b1 || level_o !== 12'd0 || motor_on_o !== 1'b0) begin
            miscompares++;
            $display("FAIL watchdog_fault: state %0d fault %b level %0d expected 4 1 0", state_o, fault_o, level_o);
        end
        brake = 1'b1;
        cycle();
        brake = 1'b0;
        vectors++;
        if (state_o !== 3'd4) begin miscompares++; $display("FAIL fault_brake: state %0d expected 4", state_o); end
        fclr = 1'b1; enable = 1'b1;
        cycle();
        vectors++;
        if (state_o !== 3'd4 || fault_o !== 1'b1) begin
            miscompares++;
            $display("FAIL fault_clear_enabled: state %0d fault %b expected 4 1", state_o, fault_o);
        end
        enable = 1'b0;
        cycle();
        fclr = 1'b0;
        vectors++;
        if (state_o !== 3'd0 || fault_o !== 1'b0) begin
            miscompares++;
            $display("FAIL fault_clear: state %0d fault %b expected 0 0", state_o, fault_o);
        end
`else
        vectors++;
        if (fault_seen || state_o !== 3'd2) begin
            miscompares++;
            $display("FAIL no_watchdog: fault_seen %b state %0d expected 0 2", fault_seen, state_o);
        end
`endif
    endtask

    task automatic test_reset_midramp();
        bit hit = 0;
        enable = 1'b0;
        for (int i = 0; i < 150 && state_o != 3'd0; i++) cycle();
        enable = 1'b1; tv = 1'b1; target = 12'd20;
        cycle();
        tv = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            cycle();
            if (state_o == 3'd1 && level_o == 12'd8) hit = 1;
        end
        vectors++;
        if (!hit) begin miscompares++; $display("FAIL midramp_setup: state %0d level %0d expected 1 8", state_o, level_o); end
        n_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            vectors++;
            if (dut_vec !== 18'h0) begin
                miscompares++;
                $display("FAIL midramp_reset %0d: got %h expected %h", i, dut_vec, 18'h0);
            end
        end
        n_reset = 1'b1;
        cycle();
        vectors++;
        if (dut_vec !== model_vec()) begin
            miscompares++;
            $display("FAIL midramp_after: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            n_reset = ($urandom_range(0, 599) != 0);
            enable  = ($urandom_range(0, 7) != 0);
            brake   = ($urandom_range(0, 47) == 0);
            tv      = (i < 2000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 79) == 0);
            target  = 12'($urandom_range(0, 160));
            fclr    = ($urandom_range(0, 15) == 0);
            cycle();
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL random cycle %0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        n_reset = 1'b1; brake = 1'b0; tv = 1'b0; fclr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_brake();
        test_stop();
        test_clamp();
        test_watchdog();
        test_reset_midramp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
